// File: rtl/block_serial_pkg.sv
// Shared types and sizing helpers for the block-serial subtractor.
package block_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of BLOCK_SIZE-bit blocks that make up one operand.
    function automatic int num_blocks(input int data_width, input int block_size);
        return data_width / block_size;
    endfunction

    // Block counter width; a single-block build still needs one bit.
    function automatic int cnt_width(input int nb);
        return (nb <= 1) ? 1 : $clog2(nb);
    endfunction

endpackage

// File: rtl/cla_block_slice.sv
// Combinational WIDTH-bit carry-lookahead slice: every carry is a flat
// sum of generate/propagate products rather than a ripple chain.
module cla_block_slice #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             acc;
    logic             prop;

    assign g = a & b;
    assign p = a ^ b;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & cin);
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial S = A - B - Bin using one carry-lookahead slice per clock.
// Define BLOCK_SERIAL_ADD_MODE_EN to add the Sub port (Sub=0 selects A + B + Bin).
module block_serial_subtractor #(
    parameter int DATA_WIDTH = 4,
    parameter int BLOCK_SIZE = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Bin,
    input  logic                  Start,
`ifdef BLOCK_SERIAL_ADD_MODE_EN
    input  logic                  Sub,
`endif
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF
);

    import block_serial_pkg::*;

    localparam int NB = num_blocks(DATA_WIDTH, BLOCK_SIZE);
    localparam int CW = cnt_width(NB);
    localparam logic [CW-1:0] LAST_BLK = CW'(NB - 1);

    generate
        if (BLOCK_SIZE < 1 || (DATA_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_cfg
            $error("block_serial_subtractor: DATA_WIDTH must be a multiple of BLOCK_SIZE");
        end
    endgenerate

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] a_sh;
    logic [DATA_WIDTH-1:0] b_sh;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  carry_q;
    logic                  sub_q;
    logic                  a_msb_q;
    logic                  b_msb_q;
    logic                  sub_sel;

    logic [BLOCK_SIZE-1:0] blk_sum;
    logic                  blk_cout;
    logic [DATA_WIDTH-1:0] res_next;
    logic                  cf_next;
    logic                  of_next;

`ifdef BLOCK_SERIAL_ADD_MODE_EN
    assign sub_sel = Sub;
`else
    assign sub_sel = 1'b1;
`endif

    // Operands shift right each cycle so the slice always sees the low block.
    cla_block_slice #(
        .WIDTH(BLOCK_SIZE)
    ) u_slice (
        .a   (a_sh[BLOCK_SIZE-1:0]),
        .b   (b_sh[BLOCK_SIZE-1:0]),
        .cin (carry_q),
        .sum (blk_sum),
        .cout(blk_cout)
    );

    // Result fills from the top; after NB cycles block 0 lands at bit 0.
    assign res_next = (res_q >> BLOCK_SIZE)
                    | (DATA_WIDTH'(blk_sum) << (DATA_WIDTH - BLOCK_SIZE));
    assign cf_next  = sub_q ? ~blk_cout : blk_cout;
    // b_msb_q holds the effective (possibly inverted) B sign, so one rule covers add and subtract.
    assign of_next  = (a_msb_q == b_msb_q) && (res_next[DATA_WIDTH-1] != a_msb_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            S       <= '0;
            CF      <= 1'b0;
            OF      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state   <= RUN;
                        Busy    <= 1'b1;
                        cnt     <= '0;
                        a_sh    <= A;
                        b_sh    <= sub_sel ? ~B : B;
                        carry_q <= sub_sel ? ~Bin : Bin;
                        sub_q   <= sub_sel;
                        a_msb_q <= A[DATA_WIDTH-1];
                        b_msb_q <= sub_sel ? ~B[DATA_WIDTH-1] : B[DATA_WIDTH-1];
                        res_q   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> BLOCK_SIZE;
                    b_sh    <= b_sh >> BLOCK_SIZE;
                    carry_q <= blk_cout;
                    res_q   <= res_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BLK) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        S     <= res_next;
                        CF    <= cf_next;
                        OF    <= of_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them on Done.
module tb_block_serial_subtractor;

    localparam int DW  = 4;
    localparam int NB1 = 4;
    localparam int NB2 = 2;
`ifdef BLOCK_SERIAL_ADD_MODE_EN
    localparam bit HAS_ADD = 1'b1;
`else
    localparam bit HAS_ADD = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] s;
        logic          cf;
        logic          of;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          bin_i;
    logic          sub_i;
    logic          start1;
    logic          start2;
    logic          busy1, done1, cf1, of1;
    logic          busy2, done2, cf2, of2;
    logic [DW-1:0] s1, s2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t mon1_e, mon2_e;
    exp_t pending1;
    exp_t last1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    block_serial_subtractor #(.DATA_WIDTH(DW), .BLOCK_SIZE(1)) u_dut (
        .CLK(clk), .RST(rst), .A(a_i), .B(b_i), .Bin(bin_i), .Start(start1),
`ifdef BLOCK_SERIAL_ADD_MODE_EN
        .Sub(sub_i),
`endif
        .Busy(busy1), .Done(done1), .S(s1), .CF(cf1), .OF(of1)
    );

    block_serial_subtractor #(.DATA_WIDTH(DW), .BLOCK_SIZE(2)) u_dut2 (
        .CLK(clk), .RST(rst), .A(a_i), .B(b_i), .Bin(bin_i), .Start(start2),
`ifdef BLOCK_SERIAL_ADD_MODE_EN
        .Sub(sub_i),
`endif
        .Busy(busy2), .Done(done2), .S(s2), .CF(cf2), .OF(of2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic bin, input logic sub);
        exp_t e;
        int   ai = int'(a);
        int   bi = int'(b);
        int   r;
        if (sub) begin
            r    = ai - bi - int'(bin);
            e.s  = r[DW-1:0];
            e.cf = (ai < bi + int'(bin));
            e.of = (a[DW-1] != b[DW-1]) && (e.s[DW-1] != a[DW-1]);
        end else begin
            r    = ai + bi + int'(bin);
            e.s  = r[DW-1:0];
            e.cf = r[DW];
            e.of = (a[DW-1] == b[DW-1]) && (e.s[DW-1] != a[DW-1]);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 1, 0);
            end else begin
                mon1_e = q1.pop_front();
                check("s1", s1, mon1_e.s);
                check("cf1", cf1, mon1_e.cf);
                check("of1", of1, mon1_e.of);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                check("done2_unexpected", 1, 0);
            end else begin
                mon2_e = q2.pop_front();
                check("s2", s2, mon2_e.s);
                check("cf2", cf2, mon2_e.cf);
                check("of2", of2, mon2_e.of);
            end
        end
    end

    // Called at a negedge while DUT1 is in IDLE or DONE; the next edge accepts.
    task automatic issue1(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic bin, input logic sub);
        a_i      = a;
        b_i      = b;
        bin_i    = bin;
        sub_i    = HAS_ADD ? sub : 1'b1;
        start1   = 1'b1;
        pending1 = model(a, b, bin, sub_i);
        q1.push_back(pending1);
    endtask

    // Runs the accepted op to its Done cycle; returns at that negedge with Start low.
    task automatic finish1(input bit hold);
        int k;
        @(posedge clk);
        #1;
        if (!hold) start1 = 1'b0;
        a_i   = DW'($urandom);
        b_i   = DW'($urandom);
        bin_i = 1'($urandom);
        sub_i = 1'($urandom);
        k = 0;
        while (1) begin
            @(negedge clk);
            if (done1) break;
            check("busy_run", busy1, 1);
            check("s_hold", s1, last1.s);
            k++;
            if (k > 20) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
        check("latency1", k, NB1);
        check("busy_in_done", busy1, 0);
        start1 = 1'b0;
        last1  = pending1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_busy", busy1, 0);
        check("idle_done", done1, 0);
    endtask

    initial begin
        int k;
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        a_i    = '0;
        b_i    = '0;
        bin_i  = 1'b0;
        sub_i  = 1'b1;
        last1  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_s", s1, 0);
        check("rst_cf", cf1, 0);
        check("rst_of", of1, 0);
        rst = 1'b0;
        idle_cycle();

        // Directed vectors.
        issue1(4'b0101, 4'b0011, 1'b0, 1'b1); finish1(1'b0); idle_cycle();
        issue1(4'b0011, 4'b0101, 1'b0, 1'b1); finish1(1'b0); idle_cycle();
        issue1(4'b0111, 4'b1000, 1'b0, 1'b1); finish1(1'b0); idle_cycle();
        issue1(4'b1000, 4'b0001, 1'b0, 1'b1); finish1(1'b0); idle_cycle();
        issue1(4'b0000, 4'b0000, 1'b1, 1'b1); finish1(1'b0); idle_cycle();

        // Start held through RUN, then back-to-back ops with no IDLE cycle.
        issue1(4'b1010, 4'b0110, 1'b1, 1'b1); finish1(1'b1); idle_cycle();
        issue1(4'b0110, 4'b1011, 1'b0, 1'b1); finish1(1'b0);
        issue1(4'b1111, 4'b0001, 1'b1, 1'b1); finish1(1'b0); idle_cycle();

        // Reset during the second RUN cycle discards the op.
        issue1(4'b0101, 4'b0011, 1'b0, 1'b1);
        @(posedge clk);
        #1 start1 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_s", s1, 0);
        check("mid_rst_cf", cf1, 0);
        check("mid_rst_of", of1, 0);
        void'(q1.pop_back());
        last1 = '0;
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        idle_cycle();

`ifdef BLOCK_SERIAL_ADD_MODE_EN
        issue1(4'b0111, 4'b0001, 1'b0, 1'b0); finish1(1'b0); idle_cycle();
        issue1(4'b1001, 4'b1000, 1'b1, 1'b0); finish1(1'b0); idle_cycle();
`endif

        // Random operations with random hold and back-to-back spacing.
        for (int i = 0; i < 40; i++) begin
            issue1(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
            finish1(bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle_cycle();
        end
        idle_cycle();

        // Two-bit blocks: same first vector, half the latency.
        a_i    = 4'b0101;
        b_i    = 4'b0011;
        bin_i  = 1'b0;
        sub_i  = 1'b1;
        start2 = 1'b1;
        q2.push_back(model(4'b0101, 4'b0011, 1'b0, 1'b1));
        @(posedge clk);
        #1 start2 = 1'b0;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (done2) break;
            check("busy2_run", busy2, 1);
            k++;
            if (k > 20) begin
                check("done2_timeout", 0, 1);
                break;
            end
        end
        check("latency2", k, NB2);
        @(negedge clk);
        check("idle2_done", done2, 0);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
